// File: rtl/cdma_pkg.sv
// rtl/cdma_pkg.sv - shared constants for the DSSS/CDMA transmit and despread paths
package cdma_pkg;
  localparam int PN_WIDTH  = 6;
  localparam int OUT_WIDTH = 8;
  localparam int AMPLITUDE = 100;
  localparam int TAP_HI    = 5;
  localparam int TAP_LO    = 0;

  localparam logic [PN_WIDTH-1:0] PN_SEED = 6'b000001;

  localparam logic signed [OUT_WIDTH-1:0] BPSK_POS = OUT_WIDTH'(AMPLITUDE);
  localparam logic signed [OUT_WIDTH-1:0] BPSK_NEG = OUT_WIDTH'(-AMPLITUDE);
endpackage

// File: rtl/pn_lfsr6.sv
// rtl/pn_lfsr6.sv - free-running x^6+x^5+1 Fibonacci LFSR, period 63
// Shared with the receiver despreader so both sides derive identical chips from the same seed.
module pn_lfsr6
  import cdma_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic [PN_WIDTH-1:0] pn_seq
);

  logic [PN_WIDTH-1:0] pn_d;
  logic [PN_WIDTH-1:0] pn_q;

  // The all-zero state is a fixed point of the LFSR; reseed rather than stall.
  always_comb begin
    pn_d = {pn_q[PN_WIDTH-2:0], pn_q[TAP_HI] ^ pn_q[TAP_LO]};
    if (pn_q == '0) begin
      pn_d = PN_SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pn_q <= PN_SEED;
    end else begin
      pn_q <= pn_d;
    end
  end

  assign pn_seq = pn_q;

endmodule

// File: rtl/cdma_transmitter.sv
// rtl/cdma_transmitter.sv - single-user DSSS chip generator with BPSK mapping
// The output is combinational from the PN state and live inputs: zero latency.
module cdma_transmitter
  import cdma_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_in,
  input  logic [PN_WIDTH-1:0]         user_code_1,
  input  logic [PN_WIDTH-1:0]         user_code_2,
  input  logic                        user_select,
  output logic signed [OUT_WIDTH-1:0] bpsk_out
);

  logic [PN_WIDTH-1:0] pn_seq;
  logic [PN_WIDTH-1:0] code;
  logic                chip;

  pn_lfsr6 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .pn_seq (pn_seq)
  );

  always_comb begin
    code     = user_select ? user_code_2 : user_code_1;
    chip     = ^(pn_seq & code);
    bpsk_out = (data_in ^ chip) ? BPSK_POS : BPSK_NEG;
  end

endmodule

// File: tb/tb_cdma_transmitter.sv
// tb/tb_cdma_transmitter.sv - scoreboard bench for two chip-synchronous cdma_transmitter instances
module tb_cdma_transmitter;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              data = 1'b1;
  logic [5:0]        uc1 = 6'b101011;
  logic [5:0]        uc2 = 6'b110101;
  logic              sel1 = 1'b0;
  logic              sel2 = 1'b1;
  logic signed [7:0] o1;
  logic signed [7:0] o2;

  logic [5:0]        model_pn = 6'b000001;
  logic signed [7:0] sb[$];
  int                n_checks = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  cdma_transmitter dut1 (
    .clk(clk), .rst(rst), .data_in(data), .user_code_1(uc1), .user_code_2(uc2),
    .user_select(sel1), .bpsk_out(o1)
  );
  cdma_transmitter dut2 (
    .clk(clk), .rst(rst), .data_in(data), .user_code_1(uc1), .user_code_2(uc2),
    .user_select(sel2), .bpsk_out(o2)
  );

  function automatic logic signed [7:0] model_out(logic [5:0] pn, logic [5:0] code, logic d);
    return (d ^ (^(pn & code))) ? 8'sd100 : -8'sd100;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst || model_pn == 6'b0) model_pn = 6'b000001;
    else model_pn = {model_pn[4:0], model_pn[5] ^ model_pn[0]};
    #2;
  endtask

  task automatic expect_model();
    sb.push_back(model_out(model_pn, sel1 ? uc2 : uc1, data));
    sb.push_back(model_out(model_pn, sel2 ? uc2 : uc1, data));
  endtask

  task automatic pop_pair(output logic signed [7:0] e1, output logic signed [7:0] e2);
    #1;
    if (sb.size() < 2) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: size %0d required >=2", sb.size());
      e1 = 8'sd0;
      e2 = 8'sd0;
    end else begin
      e1 = sb.pop_front();
      e2 = sb.pop_front();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic signed [7:0] e1, e2;
    rst = 1'b0;
    data = 1'b1;
    repeat (10) tick();
    n_checks++;
    if (dut1.u_lfsr.pn_seq !== 6'b000001 || dut2.u_lfsr.pn_seq !== 6'b000001) begin
      n_fail++;
      $display("FAIL reset_pn: got %b/%b required 000001", dut1.u_lfsr.pn_seq, dut2.u_lfsr.pn_seq);
    end
    sb.push_back(-8'sd100);
    sb.push_back(-8'sd100);
    pop_pair(e1, e2);
    n_checks++;
    if (o1 !== e1) begin n_fail++; $display("FAIL reset_u1: got %0d required %0d", o1, e1); end
    n_checks++;
    if (o2 !== e2) begin n_fail++; $display("FAIL reset_u2: got %0d required %0d", o2, e2); end
  endtask

  task automatic test_first_chips(input string tag);
    logic signed [7:0] e1, e2;
    rst = 1'b1;
    data = 1'b1;
    tick();
    sb.push_back(8'sd100);
    sb.push_back(-8'sd100);
    pop_pair(e1, e2);
    n_checks++;
    if (o1 !== e1 || o2 !== e2)
      begin n_fail++; $display("FAIL %s_chip1: got %0d/%0d required %0d/%0d", tag, o1, o2, e1, e2); end
    tick();
    sb.push_back(8'sd100);
    sb.push_back(8'sd100);
    pop_pair(e1, e2);
    n_checks++;
    if (o1 !== e1 || o2 !== e2)
      begin n_fail++; $display("FAIL %s_chip2: got %0d/%0d required %0d/%0d", tag, o1, o2, e1, e2); end
  endtask

  task automatic test_reference();
    logic signed [7:0] e1, e2;
    logic signed [7:0] s1[2][64];
    logic signed [7:0] s2[2][64];
    for (int d = 1; d >= 0; d--) begin
      data = d[0];
      do_reset();
      for (int i = 0; i < 64; i++) begin
        tick();
        expect_model();
        pop_pair(e1, e2);
        s1[d][i] = o1;
        s2[d][i] = o2;
        n_checks++;
        if (o1 !== e1 || o2 !== e2)
          begin n_fail++; $display("FAIL ref_d%0d_c%0d: got %0d/%0d required %0d/%0d", d, i, o1, o2, e1, e2); end
      end
    end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (int'(s1[0][i]) != -int'(s1[1][i]) || int'(s2[0][i]) != -int'(s2[1][i]))
        begin n_fail++; $display("FAIL negate_c%0d: got %0d/%0d required negation of %0d/%0d", i, s1[0][i], s2[0][i], s1[1][i], s2[1][i]); end
    end
  endtask

  task automatic test_period();
    logic [63:0] visited;
    logic [5:0]  pn;
    visited = '0;
    do_reset();
    for (int c = 1; c <= 63; c++) begin
      tick();
      pn = dut1.u_lfsr.pn_seq;
      n_checks++;
      if (pn !== model_pn || pn == 6'b0 || visited[pn] || (c < 63 && pn == 6'b000001)
          || dut2.u_lfsr.pn_seq !== pn)
        begin n_fail++; $display("FAIL period_c%0d: got %b required %b (unvisited, nonzero)", c, pn, model_pn); end
      visited[pn] = 1'b1;
    end
    n_checks++;
    if (pn !== 6'b000001 || $countones(visited[63:1]) != 63 || visited[0])
      begin n_fail++; $display("FAIL period_end: got pn %b visited %0d required 000001 and 63", pn, $countones(visited)); end
  endtask

  task automatic test_select_zero();
    logic signed [7:0] e1, e2;
    data = 1'b1;
    do_reset();
    repeat (5) tick();
    for (int i = 0; i < 6; i++) begin
      sel1 = ~sel1;
      expect_model();
      pop_pair(e1, e2);
      n_checks++;
      if (o1 !== e1 || o2 !== e2)
        begin n_fail++; $display("FAIL select_t%0d: got %0d/%0d required %0d/%0d", i, o1, o2, e1, e2); end
      tick();
    end
    sel1 = 1'b0;
    uc1 = 6'b000000;
    for (int i = 0; i < 12; i++) begin
      sb.push_back(8'sd100);
      sb.push_back(model_out(model_pn, uc2, data));
      pop_pair(e1, e2);
      n_checks++;
      if (o1 !== e1 || o2 !== e2)
        begin n_fail++; $display("FAIL zero_code_c%0d: got %0d/%0d required %0d/%0d", i, o1, o2, e1, e2); end
      tick();
    end
    uc1 = 6'b101011;
  endtask

  task automatic test_mid_reset();
    logic signed [7:0] e1, e2;
    data = 1'b1;
    do_reset();
    repeat (20) tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (dut1.u_lfsr.pn_seq !== 6'b000001 || dut2.u_lfsr.pn_seq !== 6'b000001)
      begin n_fail++; $display("FAIL midreset_pn: got %b/%b required 000001", dut1.u_lfsr.pn_seq, dut2.u_lfsr.pn_seq); end
    expect_model();
    pop_pair(e1, e2);
    n_checks++;
    if (o1 !== e1 || o2 !== e2)
      begin n_fail++; $display("FAIL midreset_out: got %0d/%0d required %0d/%0d", o1, o2, e1, e2); end
    test_first_chips("midreset");
  endtask

  initial begin
    test_reset();
    test_first_chips("first");
    test_reference();
    test_period();
    test_select_zero();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
